// File: rtl/game_seq_pkg.sv
// Shared types and constants for the game sequencer and its tally counters.
package game_seq_pkg;

  localparam int unsigned TALLY_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    LOAD,
    RUN,
    REPORT
  } state_t;

  typedef enum logic [1:0] {
    RES_GAMEOVER = 2'b00,
    RES_TIMEOUT  = 2'b01,
    RES_ABORT    = 2'b10
  } res_code_t;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

endpackage

// File: rtl/game_sat_tally.sv
// Clear/enable up-counter that sticks at all-ones instead of wrapping.
module game_sat_tally
  import game_seq_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [TALLY_W-1:0] cnt_o
);

  logic [TALLY_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TALLY_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/game_sequencer.sv
// Sequences one counter game per host command and returns a result record.
// Optional abort input enabled by defining GAME_SEQ_ABORT_EN.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 4,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned RUN_CYCLES   = 500,
  parameter int unsigned CYC_W        = $clog2(RUN_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_ctrl,
  input  logic [COUNTER_SIZE-1:0] cmd_load,
  output logic                    ctr_rst_l,
  output logic                    ctr_init,
  output logic [1:0]              ctr_ctrl,
  output logic [COUNTER_SIZE-1:0] ctr_load,
  input  logic                    ctr_winner,
  input  logic                    ctr_loser,
  input  logic [1:0]              ctr_who,
  input  logic                    ctr_gameover,
`ifdef GAME_SEQ_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [1:0]              res_code,
  output logic [1:0]              res_who,
  output logic [TALLY_W-1:0]      res_wins,
  output logic [TALLY_W-1:0]      res_losses,
  output logic [CYC_W-1:0]        res_cycles
);

  localparam int unsigned PH_MAX = (RST_CYCLES > INIT_CYCLES) ? RST_CYCLES : INIT_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]  RST_LAST  = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]  INIT_LAST = PH_W'(INIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_CYCLES - 1);

  state_t                  state_q;
  logic [PH_W-1:0]         ph_q;
  logic [CYC_W-1:0]        cycles_q;
  res_code_t               code_q;
  logic [1:0]              who_q;
  logic                    valid_q;
  logic                    rst_l_q;
  logic                    init_q;
  logic [1:0]              ctrl_q;
  logic [COUNTER_SIZE-1:0] load_q;
  logic                    abort_w;
  logic                    accept_w;
  logic                    win_en_w;
  logic                    lose_en_w;

`ifdef GAME_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign accept_w  = cmd_valid && cmd_ready;
  // Pulses are dropped on an abort cycle so the record reflects only completed RUN cycles.
  assign win_en_w  = (state_q == RUN) && ctr_winner && !abort_w;
  assign lose_en_w = (state_q == RUN) && ctr_loser  && !abort_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      cycles_q <= '0;
      code_q   <= RES_GAMEOVER;
      who_q    <= WHO_NONE;
      valid_q  <= 1'b0;
      rst_l_q  <= 1'b0;
      init_q   <= 1'b0;
      ctrl_q   <= '0;
      load_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            ctrl_q   <= cmd_ctrl;
            load_q   <= cmd_load;
            cycles_q <= '0;
            code_q   <= RES_GAMEOVER;
            who_q    <= WHO_NONE;
            ph_q     <= '0;
            state_q  <= RESET;
          end
        end
        RESET: begin
          if (abort_w) begin
            state_q <= REPORT;
            valid_q <= 1'b1;
            code_q  <= RES_ABORT;
            who_q   <= WHO_NONE;
          end else if (ph_q == RST_LAST) begin
            ph_q    <= '0;
            rst_l_q <= 1'b1;
            init_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        LOAD: begin
          if (abort_w) begin
            state_q <= REPORT;
            valid_q <= 1'b1;
            rst_l_q <= 1'b0;
            init_q  <= 1'b0;
            code_q  <= RES_ABORT;
            who_q   <= WHO_NONE;
          end else if (ph_q == INIT_LAST) begin
            ph_q    <= '0;
            init_q  <= 1'b0;
            state_q <= RUN;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        RUN: begin
          if (abort_w) begin
            state_q <= REPORT;
            valid_q <= 1'b1;
            rst_l_q <= 1'b0;
            code_q  <= RES_ABORT;
            who_q   <= WHO_NONE;
          end else begin
            cycles_q <= cycles_q + CYC_W'(1);
            if (ctr_gameover || (cycles_q == RUN_LAST)) begin
              state_q <= REPORT;
              valid_q <= 1'b1;
              rst_l_q <= 1'b0;
              who_q   <= ctr_who;
              code_q  <= ctr_gameover ? RES_GAMEOVER : RES_TIMEOUT;
            end
          end
        end
        REPORT: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  game_sat_tally u_wins (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept_w),
    .en_i  (win_en_w),
    .cnt_o (res_wins)
  );

  game_sat_tally u_losses (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept_w),
    .en_i  (lose_en_w),
    .cnt_o (res_losses)
  );

  assign ctr_rst_l  = rst_l_q;
  assign ctr_init   = init_q;
  assign ctr_ctrl   = ctrl_q;
  assign ctr_load   = load_q;
  assign res_valid  = valid_q;
  assign res_code   = code_q;
  assign res_who    = who_q;
  assign res_cycles = cycles_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; the bench itself plays the counter's role.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ctrl;
  logic [3:0] cmd_load;
  logic       ctr_rst_l;
  logic       ctr_init;
  logic [1:0] ctr_ctrl;
  logic [3:0] ctr_load;
  logic       ctr_winner;
  logic       ctr_loser;
  logic [1:0] ctr_who;
  logic       ctr_gameover;
  logic       abort;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_code;
  logic [1:0] res_who;
  logic [4:0] res_wins;
  logic [4:0] res_losses;
  logic [8:0] res_cycles;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .COUNTER_SIZE (4),
    .RST_CYCLES   (2),
    .INIT_CYCLES  (2),
    .RUN_CYCLES   (500)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ctrl     (cmd_ctrl),
    .cmd_load     (cmd_load),
    .ctr_rst_l    (ctr_rst_l),
    .ctr_init     (ctr_init),
    .ctr_ctrl     (ctr_ctrl),
    .ctr_load     (ctr_load),
    .ctr_winner   (ctr_winner),
    .ctr_loser    (ctr_loser),
    .ctr_who      (ctr_who),
    .ctr_gameover (ctr_gameover),
`ifdef GAME_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_code     (res_code),
    .res_who      (res_who),
    .res_wins     (res_wins),
    .res_losses   (res_losses),
    .res_cycles   (res_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a command and advance to the first RUN cycle (RST_CYCLES + INIT_CYCLES later).
  task automatic start_game(input logic [1:0] c, input logic [3:0] l);
    cmd_valid = 1'b1;
    cmd_ctrl  = c;
    cmd_load  = l;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ack_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("ack_valid_low", res_valid, 0);
    check("ack_ready_idle", cmd_ready, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 0; cmd_ctrl = 0; cmd_load = 0;
    ctr_winner = 0; ctr_loser = 0; ctr_who = 0; ctr_gameover = 0;
    abort = 0; res_ready = 0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ctr_rst_l", ctr_rst_l, 0);
    check("rst_ctr_init", ctr_init, 0);
    check("rst_ctr_ctrl", ctr_ctrl, 0);
    check("rst_ctr_load", ctr_load, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_code", res_code, 0);
    check("rst_res_wins", res_wins, 0);
    check("rst_res_cycles", res_cycles, 0);
    repeat (20) tick();
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_ctr_rst_l", ctr_rst_l, 0);
    check("idle_res_valid", res_valid, 0);

    // Basic game: accept at edge T, LOAD during T+3..T+4, 3 wins, gameover at RUN cycle 40.
    cmd_valid = 1; cmd_ctrl = 2'b01; cmd_load = 4'hF;
    tick();
    cmd_valid = 0;
    check("b_t1_ready", cmd_ready, 0);
    check("b_t1_rst_l", ctr_rst_l, 0);
    check("b_t1_init", ctr_init, 0);
    tick();
    check("b_t2_init", ctr_init, 0);
    check("b_t2_rst_l", ctr_rst_l, 0);
    tick();
    check("b_t3_init", ctr_init, 1);
    check("b_t3_rst_l", ctr_rst_l, 1);
    check("b_t3_ctrl", ctr_ctrl, 2'b01);
    check("b_t3_load", ctr_load, 4'hF);
    tick();
    check("b_t4_init", ctr_init, 1);
    tick();
    check("b_t5_init", ctr_init, 0);
    check("b_t5_rst_l", ctr_rst_l, 1);
    check("b_t5_ctrl", ctr_ctrl, 2'b01);
    for (int i = 1; i <= 40; i++) begin
      ctr_winner   = (i == 10 || i == 20 || i == 30);
      ctr_gameover = (i == 40);
      ctr_who      = (i == 40) ? 2'b10 : 2'b00;
      tick();
    end
    ctr_winner = 0; ctr_gameover = 0; ctr_who = 0;
    check("b_valid", res_valid, 1);
    check("b_code", res_code, 2'b00);
    check("b_who", res_who, 2'b10);
    check("b_wins", res_wins, 3);
    check("b_losses", res_losses, 0);
    check("b_cycles", res_cycles, 40);
    check("b_rep_rst_l", ctr_rst_l, 0);
    check("b_rep_ready", cmd_ready, 0);
    ack_result();

    // Timeout after exactly 500 RUN cycles.
    start_game(2'b10, 4'h3);
    n = 0;
    for (int i = 0; i < 600 && !res_valid; i++) begin
      tick();
      n++;
    end
    check("to_latency", n, 500);
    check("to_valid", res_valid, 1);
    check("to_code", res_code, 2'b01);
    check("to_cycles", res_cycles, 500);
    check("to_who", res_who, 2'b00);
    ack_result();

    // Gameover coincident with timeout, plus both pulses on the terminating cycle.
    start_game(2'b00, 4'h7);
    repeat (499) tick();
    ctr_winner = 1; ctr_loser = 1; ctr_gameover = 1; ctr_who = 2'b01;
    tick();
    ctr_winner = 0; ctr_loser = 0; ctr_gameover = 0; ctr_who = 0;
    check("sim_valid", res_valid, 1);
    check("sim_code", res_code, 2'b00);
    check("sim_wins", res_wins, 1);
    check("sim_losses", res_losses, 1);
    check("sim_cycles", res_cycles, 500);
    check("sim_who", res_who, 2'b01);
    ack_result();

    // Saturation, then backpressure with a stray command during REPORT.
    start_game(2'b11, 4'h1);
    for (int i = 1; i <= 40; i++) begin
      ctr_winner   = 1;
      ctr_gameover = (i == 40);
      tick();
    end
    ctr_winner = 0; ctr_gameover = 0;
    cmd_valid = 1; cmd_ctrl = 2'b10; cmd_load = 4'h5;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_wins", res_wins, 31);
      check("bp_cycles", res_cycles, 40);
      check("bp_ready", cmd_ready, 0);
      tick();
    end
    cmd_valid = 0;
    check("bp_code", res_code, 2'b00);
    check("bp_losses", res_losses, 0);
    ack_result();
    tick();
    check("bp_noqueue_ready", cmd_ready, 1);
    check("bp_noqueue_rst_l", ctr_rst_l, 0);

    // Reset during RUN cycle 7 discards the game.
    start_game(2'b01, 4'h9);
    ctr_winner = 1;
    repeat (6) tick();
    ctr_winner = 0;
    rst = 1;
    tick();
    rst = 0;
    check("mr_ready", cmd_ready, 1);
    check("mr_rst_l", ctr_rst_l, 0);
    check("mr_init", ctr_init, 0);
    check("mr_valid", res_valid, 0);
    check("mr_wins", res_wins, 0);
    check("mr_cycles", res_cycles, 0);
    check("mr_ctrl", ctr_ctrl, 0);
    repeat (3) tick();
    check("mr_valid_later", res_valid, 0);

`ifdef GAME_SEQ_ABORT_EN
    abort = 1;
    tick();
    abort = 0;
    check("ab_idle_ignored", cmd_ready, 1);
    cmd_valid = 1; cmd_ctrl = 2'b01; cmd_load = 4'h2;
    tick();
    cmd_valid = 0;
    repeat (2) tick();
    check("ab_in_load", ctr_init, 1);
    abort = 1;
    tick();
    abort = 0;
    check("ab_valid", res_valid, 1);
    check("ab_code", res_code, 2'b10);
    check("ab_cycles", res_cycles, 0);
    check("ab_who", res_who, 2'b00);
    check("ab_rst_l", ctr_rst_l, 0);
    ack_result();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Controller that sequences one counter-game instance (the `counter` block) through complete games on behalf of a host.
- Accepts a game command (ctrl mode plus load value) over a valid/ready handshake.
- Drives the counter's `rst_l`, `INIT`, `ctrl` and `loadValue`, then monitors `WINNER`/`LOSER`/`WHO`/`GAMEOVER` until the game ends or times out.
- Returns a result record over a second valid/ready handshake. Sits between the host/test sequencer and `counter`, replacing hand-timed stimulus.

Parameters:
- COUNTER_SIZE, 4, width of loadValue; must match counter.
- RST_CYCLES, 2, cycles ctr_rst_l is held low before each game (>=1).
- INIT_CYCLES, 2, cycles ctr_init is held high with ctrl/load valid (>=1).
- RUN_CYCLES, 500, max RUN cycles before timeout (>=1).
- CYC_W, $clog2(RUN_CYCLES+1), width of res_cycles.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_ctrl  in  2  counter mode for the game.
- cmd_load  in  COUNTER_SIZE  initial counter value.
- ctr_rst_l  out  1  active-low reset to counter.
- ctr_init  out  1  INIT to counter.
- ctr_ctrl  out  2  ctrl to counter.
- ctr_load  out  COUNTER_SIZE  loadValue to counter.
- ctr_winner  in  1  counter WINNER pulse.
- ctr_loser  in  1  counter LOSER pulse.
- ctr_who  in  2  counter WHO.
- ctr_gameover  in  1  counter GAMEOVER.
- res_valid  out  1  result record valid.
- res_ready  in  1  host accepts result.
- res_code  out  2  00 GAMEOVER, 01 TIMEOUT, 10 ABORT.
- res_who  out  2  ctr_who sampled at termination.
- res_wins  out  5  WINNER pulses seen in RUN, saturating at 31.
- res_losses  out  5  LOSER pulses seen in RUN, saturating at 31.
- res_cycles  out  CYC_W  RUN cycles up to and including the terminating cycle.

Behaviour:
- Outputs are registered, except cmd_ready, which is decoded from state.
- Reset values:
  - state=IDLE, ctr_rst_l=0, ctr_init=0, ctr_ctrl=0, ctr_load=0.
  - res_valid=0, res_code/res_who/res_wins/res_losses/res_cycles=0.
  - cmd_ready=1 in the first cycle after rst deasserts.
- FSM states:
  - IDLE:
    - counter held in reset (ctr_rst_l=0).
    - On cmd_valid&&cmd_ready: latch cmd_ctrl/cmd_load, clear tallies and cycle count, go to RESET.
  - RESET:
    - ctr_rst_l=0 for exactly RST_CYCLES cycles, then go to LOAD.
  - LOAD:
    - ctr_rst_l=1, ctr_init=1, ctr_ctrl/ctr_load=latched values for exactly INIT_CYCLES cycles, then go to RUN.
  - RUN:
    - ctr_init=0; ctr_ctrl holds the latched value.
    - Each cycle: res_cycles+=1; ctr_winner increments res_wins; ctr_loser increments res_losses.
    - Both pulses in the same cycle increment both tallies.
    - Terminate on ctr_gameover (code 00) or res_cycles reaching RUN_CYCLES (code 01).
    - Gameover has priority when it coincides with timeout.
    - Pulses on the terminating cycle are counted.
    - res_who is sampled from ctr_who on the terminating cycle.
  - REPORT:
    - res_valid=1 and ctr_rst_l=0; record fields stable.
    - On res_valid&&res_ready: res_valid falls next cycle and state goes to IDLE.
    - res_valid must not drop without res_ready.
- Latency: command accepted at edge T:
  - RESET occupies cycles T+1..T+RST_CYCLES.
  - LOAD occupies the following INIT_CYCLES cycles.
  - RUN starts at T+1+RST_CYCLES+INIT_CYCLES.
- Saturation: tallies stop at 31, with no wrap.
- cmd_valid outside IDLE is ignored and not queued.
- rst mid-game: next cycle is IDLE with all reset values applied. Any pending result is discarded.

Optional Feature:
- Macro GAME_SEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in RESET, LOAD or RUN moves the FSM to REPORT next cycle with res_code=10.
  - Tallies and cycles are preserved; res_who=00.
  - abort in IDLE or REPORT is ignored.
  - In RUN, abort has priority over gameover and timeout.
- Undefined: the port is absent and res_code is never 10.

Decomposition:
- Package game_seq_pkg holds:
  - state_t enum (IDLE, RESET, LOAD, RUN, REPORT);
  - res_code_t enum;
  - WHO encoding constants (WHO_NONE=00, WHO_LOSER=01, WHO_WINNER=10);
  - TALLY_W=5.
- One sub-module, game_sat_tally: a clear/enable saturating up-counter of width TALLY_W, instantiated twice (wins, losses).

Test Plan:
- Reset then idle: after rst, cmd_ready=1, ctr_rst_l=0, res_valid=0; hold cmd_valid=0 for 20 cycles -> no state change.
- Basic game: cmd ctrl=01, load=4'hF at T, stub counter pulses winner 3× and raises gameover with who=10 at RUN cycle 40:
  - ctr_init high exactly T+3..T+4;
  - result code=00, who=10, wins=3, losses=0, cycles=40.
- Timeout: RUN_CYCLES=500, stub never raises gameover -> res_code=01, res_cycles=500, res_who=00.
- Simultaneous events: winner+loser+gameover in the same cycle as cycles=RUN_CYCLES -> code=00, wins=1, losses=1.
- Backpressure and saturation:
  - 40 winner pulses -> wins=31;
  - res_ready low for 10 cycles -> res_valid and fields stable;
  - cmd_valid during REPORT ignored.
- Reset mid-RUN plus abort:
  - rst at RUN cycle 7 -> IDLE with ctr_rst_l=0 and no result.
  - With GAME_SEQ_ABORT_EN, abort in LOAD -> res_code=10, cycles=0.
